// File: rtl/imem_loader_arb_if.sv
// Signal bundle between the imem port arbiter, the fetch stage, the program loader and imem.
// The master modport drives the fetch/loader inputs; the slave modport is the arbiter itself.
interface imem_loader_arb_if;
  logic [31:0] fetch_pc;
  logic        fetch_en;
  logic        ld_req;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic        ld_err;
  logic [15:0] ld_count;
  logic [31:0] ld_checksum;
  logic        imem_en;
  logic        imem_rw;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        fetch_hold;
  logic        fetch_restart;

  modport master (
    output fetch_pc, fetch_en, ld_req, ld_valid, ld_addr, ld_data, ld_last,
    input  ld_ready, ld_done, ld_err, ld_count, ld_checksum,
    input  imem_en, imem_rw, imem_addr, imem_wdata, fetch_hold, fetch_restart
  );

  modport slave (
    input  fetch_pc, fetch_en, ld_req, ld_valid, ld_addr, ld_data, ld_last,
    output ld_ready, ld_done, ld_err, ld_count, ld_checksum,
    output imem_en, imem_rw, imem_addr, imem_wdata, fetch_hold, fetch_restart
  );
endinterface

// File: rtl/imem_loader_arb.sv
// Shares the single imem port between fetch (transparent in RUN) and a program loader (LOAD),
// then restarts fetch at BASE_ADDR. Macro IMEM_LOADER_CHECKSUM_EN enables the ld_checksum adder.
module imem_loader_arb #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int unsigned DEPTH_WORDS = 65536
) (
  input logic              clock,
  input logic              reset,
  imem_loader_arb_if.slave bus
);
  typedef enum logic [2:0] {RUN, DRAIN, LOAD, FLUSH, RESTART} state_e;

  state_e      state_q, state_d;
  logic        armed_q, armed_d;
  logic        wr_vld_q, wr_vld_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        ld_err_q, ld_err_d;
  logic [15:0] ld_count_q, ld_count_d;
  logic [31:0] word_off;
  logic        hs;
  logic        legal;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
  assign word_off = bus.ld_addr - BASE_ADDR;
  assign legal    = (bus.ld_addr[1:0] == 2'b00) && ((word_off >> 2) < DEPTH_WORDS);
  assign hs       = (state_q == LOAD) && bus.ld_valid;

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    wr_vld_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ld_err_d   = ld_err_q;
    ld_count_d = ld_count_q;
    // A new load is only accepted after ld_req has been seen low since the last restart.
    if (!bus.ld_req) armed_d = 1'b1;
    case (state_q)
      RUN: begin
        if (bus.ld_req && armed_q) state_d = DRAIN;
      end
      DRAIN: begin
        state_d    = LOAD;
        ld_err_d   = 1'b0;
        ld_count_d = '0;
      end
      LOAD: begin
        if (hs) begin
          if (legal) begin
            wr_vld_d  = 1'b1;
            wr_addr_d = bus.ld_addr;
            wr_data_d = bus.ld_data;
            if (ld_count_q != 16'hFFFF) ld_count_d = ld_count_q + 16'd1;
          end else begin
            ld_err_d = 1'b1;
          end
          if (bus.ld_last) state_d = FLUSH;
        end
      end
      FLUSH: state_d = RESTART;
      RESTART: begin
        state_d = RUN;
        armed_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    bus.imem_en       = 1'b0;
    bus.imem_rw       = 1'b0;
    bus.imem_addr     = wr_addr_q;
    bus.imem_wdata    = wr_data_q;
    bus.fetch_hold    = 1'b1;
    bus.fetch_restart = 1'b0;
    bus.ld_done       = 1'b0;
    bus.ld_ready      = 1'b0;
    case (state_q)
      RUN: begin
        bus.imem_en    = bus.fetch_en;
        bus.imem_addr  = bus.fetch_pc;
        bus.fetch_hold = 1'b0;
      end
      LOAD: begin
        bus.ld_ready = 1'b1;
        bus.imem_en  = wr_vld_q;
        bus.imem_rw  = wr_vld_q;
      end
      FLUSH: begin
        bus.imem_en = wr_vld_q;
        bus.imem_rw = wr_vld_q;
      end
      RESTART: begin
        bus.fetch_restart = 1'b1;
        bus.ld_done       = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ld_err   = ld_err_q;
  assign bus.ld_count = ld_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      armed_q    <= 1'b1;
      wr_vld_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ld_err_q   <= 1'b0;
      ld_count_q <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      wr_vld_q   <= wr_vld_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ld_err_q   <= ld_err_d;
      ld_count_q <= ld_count_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] ld_checksum_q, ld_checksum_d;

  always_comb begin
    ld_checksum_d = ld_checksum_q;
    if (state_q == DRAIN) ld_checksum_d = '0;
    else if (hs && legal) ld_checksum_d = ld_checksum_q + bus.ld_data;
  end

  always_ff @(posedge clock) begin
    if (reset) ld_checksum_q <= '0;
    else       ld_checksum_q <= ld_checksum_d;
  end

  assign bus.ld_checksum = ld_checksum_q;
`else
  assign bus.ld_checksum = '0;
`endif
endmodule
